// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : rename_regfile
// Brief    : Architectural register file with per-register ROB rename tags.
//            Optional macro RENAME_RF_BYPASS_EN forwards a matching in-flight
//            commit to the read ports in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rename_regfile #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             flush,
  input  logic             rn_en,
  input  logic [4:0]       rn_rd,
  input  logic [TAG_W-1:0] rn_tag,
  input  logic             cm_en,
  input  logic [4:0]       cm_rd,
  input  logic [TAG_W-1:0] cm_tag,
  input  logic [XLEN-1:0]  cm_val,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_ready,
  output logic [XLEN-1:0]  rs1_val,
  output logic             rs2_ready,
  output logic [XLEN-1:0]  rs2_val
);

  logic [XLEN-1:0]    r_val [REG_NUM];
  logic [TAG_W-1:0]   r_tag [REG_NUM];
  logic [REG_NUM-1:0] r_busy;

  logic w_cm_wr;
  logic w_rn_wr;
  logic w_cm_clr;

  assign w_cm_wr  = cm_en && (cm_rd != 5'd0);
  assign w_rn_wr  = rn_en && (rn_rd != 5'd0) && !flush;
  // An older producer committing must not release a register a newer rename still owns.
  assign w_cm_clr = w_cm_wr && (r_tag[cm_rd] == cm_tag) && !(w_rn_wr && (rn_rd == cm_rd));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      if (w_cm_wr) begin
        r_val[cm_rd] <= cm_val;
      end
      if (flush) begin
        r_busy <= '0;
      end else begin
        if (w_cm_clr) begin
          r_busy[cm_rd] <= 1'b0;
        end
        if (w_rn_wr) begin
          r_busy[rn_rd] <= 1'b1;
          r_tag[rn_rd]  <= rn_tag;
        end
      end
    end
  end

  // Returns {ready, value}; a pending register yields its tag zero-extended.
  function automatic logic [XLEN:0] f_read(input logic [4:0] addr);
    logic [XLEN:0] res;
    res = {1'b1, r_val[addr]};
    if (addr == 5'd0) begin
      res = {1'b1, {XLEN{1'b0}}};
    end else if (r_busy[addr]) begin
      res = {1'b0, {(XLEN-TAG_W){1'b0}}, r_tag[addr]};
`ifdef RENAME_RF_BYPASS_EN
      if (cm_en && (cm_rd == addr) && (r_tag[addr] == cm_tag)) begin
        res = {1'b1, cm_val};
      end
`endif
    end
    return res;
  endfunction

  always_comb begin
    {rs1_ready, rs1_val} = f_read(rs1_addr);
  end

  always_comb begin
    {rs2_ready, rs2_val} = f_read(rs2_addr);
  end

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_rename_regfile
// Brief    : Self-checking bench for rename_regfile: directed scenarios plus
//            randomized traffic against a behavioural register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rename_regfile;
  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int TAG_W   = 4;

  logic             clk;
  logic             rst_n;
  logic             rdy;
  logic             flush;
  logic             rn_en;
  logic [4:0]       rn_rd;
  logic [TAG_W-1:0] rn_tag;
  logic             cm_en;
  logic [4:0]       cm_rd;
  logic [TAG_W-1:0] cm_tag;
  logic [XLEN-1:0]  cm_val;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic             rs1_ready;
  logic [XLEN-1:0]  rs1_val;
  logic             rs2_ready;
  logic [XLEN-1:0]  rs2_val;

  int checks   = 0;
  int failures = 0;

  // Reference model: committed values, pending flags and owning tags.
  logic [XLEN-1:0]  m_val  [REG_NUM];
  bit               m_busy [REG_NUM];
  logic [TAG_W-1:0] m_tag  [REG_NUM];

  rename_regfile #(.XLEN(XLEN), .REG_NUM(REG_NUM), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .flush     (flush),
    .rn_en     (rn_en),
    .rn_rd     (rn_rd),
    .rn_tag    (rn_tag),
    .cm_en     (cm_en),
    .cm_rd     (cm_rd),
    .cm_tag    (cm_tag),
    .cm_val    (cm_val),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_ready (rs1_ready),
    .rs1_val   (rs1_val),
    .rs2_ready (rs2_ready),
    .rs2_val   (rs2_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void m_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endfunction

  // Applies one clock edge's worth of architectural rules to the model.
  function automatic void m_edge();
    bit release_it;
    if (!rdy) return;
    release_it = 1'b0;
    if (cm_en && cm_rd != 0) begin
      m_val[cm_rd] = cm_val;
      release_it   = (m_tag[cm_rd] == cm_tag);
    end
    if (flush) begin
      for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
    end else begin
      if (release_it) m_busy[cm_rd] = 1'b0;
      if (rn_en && rn_rd != 0) begin
        m_busy[rn_rd] = 1'b1;
        m_tag[rn_rd]  = rn_tag;
      end
    end
  endfunction

  function automatic void m_read(input logic [4:0] a, output logic r, output logic [XLEN-1:0] v);
    if (a == 0) begin
      r = 1'b1; v = '0;
    end else if (!m_busy[a]) begin
      r = 1'b1; v = m_val[a];
    end else begin
      r = 1'b0; v = XLEN'(m_tag[a]);
`ifdef RENAME_RF_BYPASS_EN
      if (cm_en && cm_rd == a && m_tag[a] == cm_tag) begin
        r = 1'b1; v = cm_val;
      end
`endif
    end
  endfunction

  task automatic idle();
    rdy = 1'b1; flush = 1'b0;
    rn_en = 1'b0; rn_rd = '0; rn_tag = '0;
    cm_en = 1'b0; cm_rd = '0; cm_tag = '0; cm_val = '0;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ren, input logic [4:0] rrd, input logic [TAG_W-1:0] rtag,
                       input logic cen, input logic [4:0] crd, input logic [TAG_W-1:0] ctag,
                       input logic [XLEN-1:0] cv, input logic fl);
    rn_en = ren; rn_rd = rrd; rn_tag = rtag;
    cm_en = cen; cm_rd = crd; cm_tag = ctag; cm_val = cv; flush = fl;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    #1 rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0 || rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      failures++;
      $display("FAIL reset_during x5: rdy=%0b val=%h x0: rdy=%0b val=%h, required all ready=1 val=0",
               rs1_ready, rs1_val, rs2_ready, rs2_val);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0) begin
      failures++;
      $display("FAIL reset_x5 ready=%0b val=%h required ready=1 val=0", rs1_ready, rs1_val);
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 5'd0, 4'd7, 1'b1, 5'd0, 4'd7, 32'h1234, 1'b0);
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0 || rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      failures++;
      $display("FAIL x0_write p1 rdy=%0b val=%h p2 rdy=%0b val=%h required ready=1 val=0",
               rs1_ready, rs1_val, rs2_ready, rs2_val);
    end
  endtask

  task automatic test_rename_commit();
    rs1_addr = 5'd5;
    drive(1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    checks++;
    if (rs1_ready !== 1'b0 || rs1_val !== 32'd3) begin
      failures++;
      $display("FAIL rename_x5 ready=%0b val=%h required ready=0 val=3", rs1_ready, rs1_val);
    end
    drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 4'd3, 32'hDEADBEEF, 1'b0);
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL commit_x5 ready=%0b val=%h required ready=1 val=deadbeef", rs1_ready, rs1_val);
    end
  endtask

  task automatic test_multi_rename();
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    drive(1'b1, 5'd7, 4'd2, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    drive(1'b1, 5'd7, 4'd9, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 4'd2, 32'h11, 1'b0);
    checks++;
    if (rs1_ready !== 1'b0 || rs1_val !== 32'd9 || rs2_ready !== 1'b0 || rs2_val !== 32'd9) begin
      failures++;
      $display("FAIL older_commit_x7 p1 rdy=%0b val=%h p2 rdy=%0b val=%h required ready=0 val=9",
               rs1_ready, rs1_val, rs2_ready, rs2_val);
    end
    drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 4'd9, 32'h22, 1'b0);
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h22) begin
      failures++;
      $display("FAIL newest_commit_x7 ready=%0b val=%h required ready=1 val=22", rs1_ready, rs1_val);
    end
  endtask

  task automatic test_same_cycle();
    rs2_addr = 5'd4;
    drive(1'b1, 5'd4, 4'd1, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    drive(1'b1, 5'd4, 4'd6, 1'b1, 5'd4, 4'd1, 32'h55, 1'b0);
    checks++;
    if (rs2_ready !== 1'b0 || rs2_val !== 32'd6) begin
      failures++;
      $display("FAIL same_cycle_x4 ready=%0b val=%h required ready=0 val=6", rs2_ready, rs2_val);
    end
    drive(1'b0, 5'd0, 4'd0, 1'b1, 5'd4, 4'd6, 32'h66, 1'b0);
    checks++;
    if (rs2_ready !== 1'b1 || rs2_val !== 32'h66) begin
      failures++;
      $display("FAIL same_cycle_commit_x4 ready=%0b val=%h required ready=1 val=66", rs2_ready, rs2_val);
    end
  endtask

  task automatic test_flush();
    logic [4:0]      addrs [4];
    logic [XLEN-1:0] vals  [4];
    addrs = '{5'd1, 5'd2, 5'd3, 5'd8};
    vals  = '{32'h0, 32'h77, 32'h0, 32'h0};
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 5'(i), 4'(i), 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    end
    drive(1'b1, 5'd8, 4'd5, 1'b1, 5'd2, 4'd2, 32'h77, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rs1_addr = addrs[i];
      #1;
      checks++;
      if (rs1_ready !== 1'b1 || rs1_val !== vals[i]) begin
        failures++;
        $display("FAIL flush_x%0d ready=%0b val=%h required ready=1 val=%h",
                 addrs[i], rs1_ready, rs1_val, vals[i]);
      end
    end
  endtask

  task automatic test_bypass();
    logic            exp_r;
    logic [XLEN-1:0] exp_v;
    rs1_addr = 5'd5;
    drive(1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    cm_en = 1'b1; cm_rd = 5'd5; cm_tag = 4'd3; cm_val = 32'hAB;
    #1;
`ifdef RENAME_RF_BYPASS_EN
    exp_r = 1'b1; exp_v = 32'hAB;
`else
    exp_r = 1'b0; exp_v = 32'd3;
`endif
    checks++;
    if (rs1_ready !== exp_r || rs1_val !== exp_v) begin
      failures++;
      $display("FAIL bypass_same_cycle ready=%0b val=%h required ready=%0b val=%h",
               rs1_ready, rs1_val, exp_r, exp_v);
    end
    tick();
    idle();
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'hAB) begin
      failures++;
      $display("FAIL bypass_next_cycle ready=%0b val=%h required ready=1 val=ab", rs1_ready, rs1_val);
    end
  endtask

  task automatic test_hold();
    rs1_addr = 5'd12; rs2_addr = 5'd13;
    drive(1'b1, 5'd12, 4'd7, 1'b0, 5'd0, 4'd0, 32'h0, 1'b0);
    rdy = 1'b0; rn_en = 1'b1; rn_rd = 5'd12; rn_tag = 4'd8;
    cm_en = 1'b1; cm_rd = 5'd13; cm_tag = 4'd0; cm_val = 32'h99;
    tick();
    flush = 1'b1; rn_en = 1'b0; cm_en = 1'b0;
    tick();
    idle();
    checks++;
    if (rs1_ready !== 1'b0 || rs1_val !== 32'd7 || rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      failures++;
      $display("FAIL hold_rdy0 x12 rdy=%0b val=%h x13 rdy=%0b val=%h required x12 0/7 x13 1/0",
               rs1_ready, rs1_val, rs2_ready, rs2_val);
    end
  endtask

  task automatic test_async_reset();
    rs1_addr = 5'd9; rs2_addr = 5'd10;
    drive(1'b1, 5'd9, 4'd4, 1'b1, 5'd10, 4'd0, 32'hCAFE, 1'b0);
    rn_en = 1'b1; rn_rd = 5'd11; rn_tag = 4'd2;
    cm_en = 1'b1; cm_rd = 5'd10; cm_tag = 4'd1; cm_val = 32'hBEEF;
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0 || rs2_ready !== 1'b1 || rs2_val !== 32'h0) begin
      failures++;
      $display("FAIL async_reset x9 rdy=%0b val=%h x10 rdy=%0b val=%h required ready=1 val=0",
               rs1_ready, rs1_val, rs2_ready, rs2_val);
    end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle();
    rs1_addr = 5'd11;
    @(posedge clk) #1;
    checks++;
    if (rs1_ready !== 1'b1 || rs1_val !== 32'h0 || rs2_val !== 32'h0) begin
      failures++;
      $display("FAIL reset_discards x11 rdy=%0b val=%h x10 val=%h required ready=1 val=0",
               rs1_ready, rs1_val, rs2_val);
    end
  endtask

  task automatic test_random();
    logic            e1_r, e2_r;
    logic [XLEN-1:0] e1_v, e2_v;
    for (int n = 0; n < 400; n++) begin
      rdy    = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 19) == 0);
      rn_en  = $urandom_range(0, 1);
      rn_rd  = 5'($urandom_range(0, 7));
      rn_tag = 4'($urandom);
      cm_en  = $urandom_range(0, 1);
      cm_rd  = ($urandom_range(0, 3) == 0) ? rn_rd : 5'($urandom_range(0, 7));
      cm_tag = ($urandom_range(0, 1) == 0) ? m_tag[cm_rd] : 4'($urandom);
      cm_val = $urandom;
      rs1_addr = ($urandom_range(0, 1) == 0) ? cm_rd : 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      #1;
      m_read(rs1_addr, e1_r, e1_v);
      m_read(rs2_addr, e2_r, e2_v);
      checks++;
      if (rs1_ready !== e1_r || rs1_val !== e1_v) begin
        failures++;
        $display("FAIL random_rs1 n=%0d x%0d ready=%0b val=%h required ready=%0b val=%h",
                 n, rs1_addr, rs1_ready, rs1_val, e1_r, e1_v);
      end
      checks++;
      if (rs2_ready !== e2_r || rs2_val !== e2_v) begin
        failures++;
        $display("FAIL random_rs2 n=%0d x%0d ready=%0b val=%h required ready=%0b val=%h",
                 n, rs2_addr, rs2_ready, rs2_val, e2_r, e2_v);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rs1_addr = '0;
    rs2_addr = '0;
    test_reset();
    test_x0();
    test_rename_commit();
    test_multi_rename();
    test_same_cycle();
    test_flush();
    test_bypass();
    test_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
